// File: rtl/mem_arbiter_if.sv
// Bus bundle between two memory requesters, the arbiter and a single-port RAM.
// The master modport is the requester/RAM side; the slave modport is the arbiter.
interface mem_arbiter_if #(
    parameter int AW = 9,
    parameter int DW = 16
);
    logic          req0;
    logic          req1;
    logic [1:0]    cmd0;
    logic [1:0]    cmd1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] rdata;
    logic [1:0]    grant;
    logic          busy;
    logic [1:0]    mem_cmd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        output req0, req1, cmd0, cmd1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  ack0, ack1, rdata, grant, busy, mem_cmd, mem_addr, mem_wdata
    );

    modport slave (
        input  req0, req1, cmd0, cmd1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack0, ack1, rdata, grant, busy, mem_cmd, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port RAM: IDLE->ISSUE->CAPTURE->ACK per access.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise requester 0 has fixed priority.
module mem_arbiter #(
    parameter int AW = 9,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_ACK     = 2'd3;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    function automatic logic is_access(input logic req, input logic [1:0] cmd);
        return req && ((cmd == CMD_READ) || (cmd == CMD_WRITE));
    endfunction

    logic [1:0]    state_q,     state_d;
    logic [1:0]    cmd_q,       cmd_d;
    logic          win_q,       win_d;
    logic [1:0]    grant_q,     grant_d;
    logic [1:0]    ack_q,       ack_d;
    logic          busy_q,      busy_d;
    logic [1:0]    mem_cmd_q,   mem_cmd_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] rdata_q,     rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic          ptr_q,       ptr_d;
`endif

    logic          elig0_s;
    logic          elig1_s;
    logic          pick_s;
    logic [1:0]    sel_cmd_s;
    logic [AW-1:0] sel_addr_s;
    logic [DW-1:0] sel_wdata_s;

    assign elig0_s = is_access(bus.req0, bus.cmd0);
    assign elig1_s = is_access(bus.req1, bus.cmd1);

    // Winner selection among eligible requesters
    always_comb begin
        pick_s = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (elig0_s && elig1_s) begin
            pick_s = ~ptr_q;
        end else if (elig1_s) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
`else
        if (elig0_s) begin
            pick_s = 1'b0;
        end else if (elig1_s) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
`endif
    end

    // Mux the winner's request fields
    always_comb begin
        sel_cmd_s   = bus.cmd0;
        sel_addr_s  = bus.addr0;
        sel_wdata_s = bus.wdata0;
        if (pick_s) begin
            sel_cmd_s   = bus.cmd1;
            sel_addr_s  = bus.addr1;
            sel_wdata_s = bus.wdata1;
        end else begin
            sel_cmd_s   = bus.cmd0;
            sel_addr_s  = bus.addr0;
            sel_wdata_s = bus.wdata0;
        end
    end

    // Next-state and next-output computation; outputs are all registered
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        win_d       = win_q;
        grant_d     = grant_q;
        ack_d       = 2'b00;
        busy_d      = busy_q;
        mem_cmd_d   = CMD_NONE;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (elig0_s || elig1_s) begin
                    state_d     = S_ISSUE;
                    cmd_d       = sel_cmd_s;
                    win_d       = pick_s;
                    grant_d     = pick_s ? 2'b10 : 2'b01;
                    busy_d      = 1'b1;
                    mem_cmd_d   = sel_cmd_s;
                    mem_addr_d  = sel_addr_s;
                    mem_wdata_d = sel_wdata_s;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    ptr_d       = pick_s;
`endif
                end else begin
                    state_d = S_IDLE;
                    grant_d = 2'b00;
                    busy_d  = 1'b0;
                end
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_d = S_ACK;
                ack_d   = win_q ? 2'b10 : 2'b01;
                // RAM data for a read is valid during this cycle only
                if (cmd_q == CMD_READ) begin
                    rdata_d = bus.mem_rdata;
                end else begin
                    rdata_d = rdata_q;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any access in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cmd_q       <= CMD_NONE;
            win_q       <= 1'b0;
            grant_q     <= 2'b00;
            ack_q       <= 2'b00;
            busy_q      <= 1'b0;
            mem_cmd_q   <= CMD_NONE;
            mem_addr_q  <= {AW{1'b0}};
            mem_wdata_q <= {DW{1'b0}};
            rdata_q     <= {DW{1'b0}};
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ptr_q       <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            win_q       <= win_d;
            grant_q     <= grant_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            mem_cmd_q   <= mem_cmd_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign bus.ack0      = ack_q[0];
    assign bus.ack1      = ack_q[1];
    assign bus.grant     = grant_q;
    assign bus.busy      = busy_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_cmd   = mem_cmd_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule
